sipo_deserializer: RTL

Serial-in/parallel-out front end that assembles a 1-bit serial stream into WIDTH-bit words and presents them on a valid/ready parallel port. It sits directly upstream of the 4-bit parallel-in/parallel-out register stage and drives that stage's parallel data input. Double buffering (shift register plus output holding register) sustains 1 bit/cycle with no bubbles while the consumer is ready, and applies serial backpressure when it is not.

---
 rtl/sipo_deserializer.sv | 110 +++++++++++
 1 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles a 1-bit stream into WIDTH-bit words
// and double-buffers them (shift register + output holding register) onto a valid/ready port.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             pending_reg, pending_next;
  logic [WIDTH-1:0] pout_reg, pout_next;
  logic             pout_valid_reg, pout_valid_next;
  logic [WIDTH-1:0] shifted;
  logic             accept, slot_free, complete;

  // Shift register contents after inserting sin, in the configured bit order.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_ins
          assign shifted[gi] = sin;
        end else begin : g_mov
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_ins
          assign shifted[gi] = sin;
        end else begin : g_mov
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  // Backpressure comes from a register only, never from sin_valid.
  assign sin_ready  = !pending_reg;
  assign accept     = sin_valid && sin_ready;
  assign slot_free  = !pout_valid_reg || pout_ready;
  assign complete   = accept && (count_reg == LAST);
  assign pout       = pout_reg;
  assign pout_valid = pout_valid_reg;

  always_comb begin
    shift_next      = shift_reg;
    count_next      = count_reg;
    pending_next    = pending_reg;
    pout_next       = pout_reg;
    pout_valid_next = pout_valid_reg;

    // A consumed word drops valid unless something below refills the slot this edge.
    if (pout_valid_reg && pout_ready) begin
      pout_valid_next = 1'b0;
    end

    if (clear) begin
      shift_next   = '0;
      count_next   = '0;
      pending_next = 1'b0;
    end else if (pending_reg) begin
      if (slot_free) begin
        pout_next       = shift_reg;
        pout_valid_next = 1'b1;
        pending_next    = 1'b0;
      end
    end else if (complete) begin
      shift_next = shifted;
      count_next = '0;
      if (slot_free) begin
        pout_next       = shifted;
        pout_valid_next = 1'b1;
      end else begin
        pending_next = 1'b1;
      end
    end else if (accept) begin
      shift_next = shifted;
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg      <= '0;
      count_reg      <= '0;
      pending_reg    <= 1'b0;
      pout_reg       <= '0;
      pout_valid_reg <= 1'b0;
    end else begin
      shift_reg      <= shift_next;
      count_reg      <= count_next;
      pending_reg    <= pending_next;
      pout_reg       <= pout_next;
      pout_valid_reg <= pout_valid_next;
    end
  end

endmodule
